// File: rtl/coeff_bank_rom.sv
// Double-banked FIR coefficient store: registered reads from the active bank,
// framed valid/ready reload of the shadow bank, and an atomic bank swap.
module coeff_bank_rom #(
    parameter  int WIDTH    = 8,
    parameter  int NTAPS    = 16,
    parameter  int READ_LAT = 1,
    localparam int AW       = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic [AW-1:0]    addra,
    output logic [WIDTH-1:0] douta,
    output logic             bank_sel,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_done,
    output logic             ld_err,
    input  logic             swap_req
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ARMED = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] default_coeff(input int idx);
        int v;
        case (idx)
            0:       v = 32'sd2;
            1:       v = -32'sd5;
            2:       v = 32'sd3;
            3:       v = 32'sd1;
            4:       v = -32'sd4;
            5:       v = 32'sd3;
            6:       v = 32'sd4;
            7:       v = 32'sd3;
            8:       v = 32'sd5;
            9:       v = 32'sd2;
            10:      v = 32'sd1;
            11:      v = 32'sd1;
            12:      v = -32'sd2;
            13:      v = 32'sd3;
            14:      v = 32'sd4;
            15:      v = 32'sd1;
            default: v = 32'sd0;
        endcase
        return WIDTH'(v);
    endfunction

    logic [WIDTH-1:0] mem_r [2][NTAPS];
    state_t           state_r, state_next_s;
    logic [AW-1:0]    wptr_r, wptr_next_s;
    logic             bank_sel_r, ld_ready_r, ld_done_r, ld_err_r;
    logic             wr_en_s, err_s, swap_s, fire_s, last_slot_s, in_range_s;
    logic [WIDTH-1:0] rd1_r;

    assign fire_s      = ld_valid && ld_ready_r;
    assign last_slot_s = ({1'b0, wptr_r} == (AW+1)'(NTAPS - 1));
    assign in_range_s  = ({1'b0, addra} < (AW+1)'(NTAPS));

    // Frame tracking; IDLE always has wptr == 0, so it shares the LOAD rules.
    always_comb begin
        state_next_s = state_r;
        wptr_next_s  = wptr_r;
        wr_en_s      = 1'b0;
        err_s        = 1'b0;
        swap_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (fire_s) begin
                    wr_en_s     = 1'b1;
                    wptr_next_s = wptr_r + AW'(1);
                    if (ld_last && last_slot_s) begin
                        state_next_s = ST_ARMED;
                    end else if (ld_last) begin
                        err_s        = 1'b1;
                        state_next_s = ST_IDLE;
                        wptr_next_s  = '0;
                    end else if (last_slot_s) begin
                        err_s        = 1'b1;
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (fire_s && ld_last) begin
                    state_next_s = ST_IDLE;
                    wptr_next_s  = '0;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_ARMED: begin
                if (swap_req) begin
                    swap_s       = 1'b1;
                    state_next_s = ST_IDLE;
                    wptr_next_s  = '0;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                wptr_next_s  = '0;
            end
        endcase
    end

    // Control state and registered status outputs.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_r    <= ST_IDLE;
            wptr_r     <= '0;
            bank_sel_r <= 1'b0;
            ld_err_r   <= 1'b0;
            ld_done_r  <= 1'b0;
            ld_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            wptr_r     <= wptr_next_s;
            bank_sel_r <= swap_s ? ~bank_sel_r : bank_sel_r;
            ld_err_r   <= err_s;
            ld_done_r  <= (state_next_s == ST_ARMED);
            ld_ready_r <= (state_next_s != ST_ARMED);
        end
    end

    // Coefficient banks: writes only ever land in the inactive bank.
    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem_r[0][i] <= default_coeff(i);
                mem_r[1][i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[~bank_sel_r][wptr_r] <= ld_data;
        end
    end

    // First read stage; addresses past the last tap read as zero.
    always_ff @(posedge clka) begin
        if (rsta) begin
            rd1_r <= '0;
        end else begin
            rd1_r <= in_range_s ? mem_r[bank_sel_r][addra] : '0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] rd2_r;
            // Optional second output register.
            always_ff @(posedge clka) begin
                if (rsta) begin
                    rd2_r <= '0;
                end else begin
                    rd2_r <= rd1_r;
                end
            end
            assign douta = rd2_r;
        end else begin : g_lat1
            assign douta = rd1_r;
        end
    endgenerate

    assign bank_sel = bank_sel_r;
    assign ld_ready = ld_ready_r;
    assign ld_done  = ld_done_r;
    assign ld_err   = ld_err_r;

endmodule

// File: tb/tb_coeff_bank_rom.sv
// Self-checking bench for coeff_bank_rom: directed scenarios plus randomized
// traffic compared against a frame-level reference model.
module tb_coeff_bank_rom;

    logic       clka = 1'b0;
    always #5 clka = ~clka;

    logic       rsta = 1'b1;
    logic [3:0] addra = 4'd0;
    logic [7:0] douta;
    logic       bank_sel, ld_ready, ld_done, ld_err;
    logic       ld_valid = 1'b0, ld_last = 1'b0, swap_req = 1'b0;
    logic [7:0] ld_data = 8'h00;

    logic [2:0]  addra_b = 3'd0;
    logic [11:0] douta_b;
    logic        bank_sel_b, ld_ready_b, ld_done_b, ld_err_b;
    logic [3:0]  addra_c = 4'd0;
    logic [7:0]  douta_c;
    logic        bank_sel_c, ld_ready_c, ld_done_c, ld_err_c;

    coeff_bank_rom dut (
        .clka(clka), .rsta(rsta), .addra(addra), .douta(douta), .bank_sel(bank_sel),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .ld_done(ld_done), .ld_err(ld_err), .swap_req(swap_req)
    );

    coeff_bank_rom #(.WIDTH(12), .NTAPS(8), .READ_LAT(2)) dut_b (
        .clka(clka), .rsta(rsta), .addra(addra_b), .douta(douta_b), .bank_sel(bank_sel_b),
        .ld_valid(1'b0), .ld_ready(ld_ready_b), .ld_data(12'h000), .ld_last(1'b0),
        .ld_done(ld_done_b), .ld_err(ld_err_b), .swap_req(1'b0)
    );

    coeff_bank_rom #(.WIDTH(8), .NTAPS(12), .READ_LAT(1)) dut_c (
        .clka(clka), .rsta(rsta), .addra(addra_c), .douta(douta_c), .bank_sel(bank_sel_c),
        .ld_valid(1'b0), .ld_ready(ld_ready_c), .ld_data(8'h00), .ld_last(1'b0),
        .ld_done(ld_done_c), .ld_err(ld_err_c), .swap_req(1'b0)
    );

    int         def_int [16] = '{2, -5, 3, 1, -4, 3, 4, 3, 5, 2, 1, 1, -2, 3, 4, 1};
    logic [7:0] exp_def [16] = '{8'h02, 8'hFB, 8'h03, 8'h01, 8'hFC, 8'h03, 8'h04, 8'h03,
                                 8'h05, 8'h02, 8'h01, 8'h01, 8'hFE, 8'h03, 8'h04, 8'h01};

    // Reference model: two banks, the active index, and the frame being collected.
    logic [7:0] m_bank [2][16];
    logic       m_sel = 1'b0, m_armed = 1'b0, m_drain = 1'b0;
    logic [7:0] m_q [$];
    logic [7:0] exp_dout = 8'h00;
    logic       exp_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Advance the model by one clock using the currently driven inputs, then the DUT.
    task automatic tick();
        logic [7:0] rd;
        rd      = m_bank[m_sel][addra];
        exp_err = 1'b0;
        if (rsta) begin
            m_sel = 1'b0; m_armed = 1'b0; m_drain = 1'b0; m_q.delete();
            for (int i = 0; i < 16; i++) begin
                m_bank[0][i] = 8'(def_int[i]);
                m_bank[1][i] = 8'h00;
            end
            exp_dout = 8'h00;
        end else begin
            exp_dout = rd;
            if (!m_armed) begin
                if (ld_valid) begin
                    if (m_drain) begin
                        if (ld_last) m_drain = 1'b0;
                    end else begin
                        m_q.push_back(ld_data);
                        if (m_q.size() == 16) begin
                            if (ld_last) begin
                                for (int i = 0; i < 16; i++) m_bank[!m_sel][i] = m_q[i];
                                m_armed = 1'b1;
                            end else begin
                                exp_err = 1'b1;
                                m_drain = 1'b1;
                            end
                            m_q.delete();
                        end else if (ld_last) begin
                            exp_err = 1'b1;
                            m_q.delete();
                        end
                    end
                end
            end else if (swap_req) begin
                m_sel   = ~m_sel;
                m_armed = 1'b0;
            end
        end
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        rsta = 1'b1;
        tick();
        tick();
        rsta = 1'b0;
        n_tests++;
        if ({douta, bank_sel, ld_done, ld_ready, ld_err} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got %h/%b%b%b%b want 00/0010", douta, bank_sel, ld_done, ld_ready, ld_err);
        end
        for (int i = 0; i < 16; i++) begin
            addra = 4'(i);
            tick();
            n_tests++;
            if (douta !== exp_def[i] || bank_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL default_sweep[%0d] got %h sel %b want %h sel 0", i, douta, bank_sel, exp_def[i]);
            end
        end
    endtask

    task automatic test_params();
        n_tests++;
        if ({bank_sel_b, ld_ready_b, ld_done_b, ld_err_b, bank_sel_c, ld_ready_c, ld_done_c, ld_err_c} !== 8'b0100_0100) begin
            n_fail++;
            $display("FAIL param_status got %b%b%b%b %b%b%b%b want 0100 0100", bank_sel_b, ld_ready_b,
                     ld_done_b, ld_err_b, bank_sel_c, ld_ready_c, ld_done_c, ld_err_c);
        end
        addra_b = 3'd1;
        tick();
        n_tests++;
        if (douta_b !== 12'h002) begin n_fail++; $display("FAIL lat2_first_edge got %h want 002", douta_b); end
        tick();
        n_tests++;
        if (douta_b !== 12'hFFB) begin n_fail++; $display("FAIL lat2_addr1 got %h want FFB", douta_b); end
        addra_b = 3'd7;
        tick();
        tick();
        n_tests++;
        if (douta_b !== 12'h003) begin n_fail++; $display("FAIL lat2_addr7 got %h want 003", douta_b); end
        addra_c = 4'd11;
        tick();
        n_tests++;
        if (douta_c !== 8'h01) begin n_fail++; $display("FAIL ntaps12_addr11 got %h want 01", douta_c); end
        addra_c = 4'd13;
        tick();
        n_tests++;
        if (douta_c !== 8'h00) begin n_fail++; $display("FAIL out_of_range_13 got %h want 00", douta_c); end
        addra_c = 4'd4;
        tick();
        addra_c = 4'd12;
        tick();
        n_tests++;
        if (douta_c !== 8'h00) begin n_fail++; $display("FAIL out_of_range_12 got %h want 00", douta_c); end
    endtask

    task automatic test_full_load();
        ld_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld_data = 8'h10 + 8'(i);
            ld_last = (i == 15);
            addra   = 4'($urandom_range(0, 15));
            tick();
            n_tests++;
            if ({douta, ld_err, ld_ready} !== {exp_dout, 1'b0, (i != 15)}) begin
                n_fail++;
                $display("FAIL load_word[%0d] got %h/%b%b want %h/0%b", i, douta, ld_err, ld_ready, exp_dout, (i != 15));
            end
        end
        ld_last = 1'b0;
        addra   = 4'd2;
        tick();
        n_tests++;
        if ({douta, ld_done, ld_ready, bank_sel} !== {8'h03, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL armed_state got %h/%b%b%b want 03/100", douta, ld_done, ld_ready, bank_sel);
        end
        ld_valid = 1'b0;
        swap_req = 1'b1;
        addra    = 4'd5;
        tick();
        swap_req = 1'b0;
        n_tests++;
        if (bank_sel !== 1'b1 || douta !== exp_def[5]) begin
            n_fail++;
            $display("FAIL swap_edge got sel %b data %h want sel 1 data %h", bank_sel, douta, exp_def[5]);
        end
        tick();
        n_tests++;
        if (douta !== 8'h15 || ld_done !== 1'b0) begin
            n_fail++;
            $display("FAIL new_bank_addr5 got %h done %b want 15 done 0", douta, ld_done);
        end
    endtask

    task automatic test_short_frame();
        ld_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_data = 8'($urandom);
            ld_last = (i == 9);
            addra   = 4'(i);
            tick();
            n_tests++;
            if ({ld_err, douta} !== {(i == 9), 8'h10 + 8'(i)}) begin
                n_fail++;
                $display("FAIL short_frame[%0d] got err %b data %h want err %b data %h", i, ld_err, douta, (i == 9), 8'h10 + 8'(i));
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        n_tests++;
        if ({ld_err, ld_done, ld_ready, bank_sel} !== 4'b0011) begin
            n_fail++;
            $display("FAIL short_frame_after got %b%b%b%b want 0011", ld_err, ld_done, ld_ready, bank_sel);
        end
    endtask

    task automatic test_long_frame();
        ld_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ld_data = 8'($urandom);
            ld_last = (i == 19);
            addra   = 4'(i % 16);
            tick();
            n_tests++;
            if ({ld_err, ld_done, ld_ready, douta} !== {(i == 15), 1'b0, 1'b1, 8'h10 + 8'(i % 16)}) begin
                n_fail++;
                $display("FAIL long_frame[%0d] got %b%b%b %h want %b01 %h", i, ld_err, ld_done, ld_ready, douta,
                         (i == 15), 8'h10 + 8'(i % 16));
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        n_tests++;
        if ({ld_err, ld_done, bank_sel} !== 3'b001) begin
            n_fail++;
            $display("FAIL long_frame_after got %b%b%b want 001", ld_err, ld_done, bank_sel);
        end
    endtask

    task automatic test_swap_ignored_and_reset();
        logic [7:0] words [16];
        swap_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_valid = (i >= 3);
            ld_data  = 8'($urandom);
            tick();
            n_tests++;
            if (bank_sel !== 1'b1 || ld_done !== 1'b0) begin
                n_fail++;
                $display("FAIL swap_ignored[%0d] got sel %b done %b want sel 1 done 0", i, bank_sel, ld_done);
            end
        end
        swap_req = 1'b0;
        ld_valid = 1'b0;
        rsta     = 1'b1;
        tick();
        rsta = 1'b0;
        n_tests++;
        if ({douta, bank_sel, ld_done, ld_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midload_reset got %h/%b%b%b want 00/001", douta, bank_sel, ld_done, ld_ready);
        end
        for (int i = 0; i < 16; i += 3) begin
            addra = 4'(i);
            tick();
            n_tests++;
            if (douta !== exp_def[i]) begin n_fail++; $display("FAIL restored_default[%0d] got %h want %h", i, douta, exp_def[i]); end
        end
        ld_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            words[i] = 8'($urandom);
            ld_data  = words[i];
            ld_last  = (i == 15);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_tests++;
        if (ld_done !== 1'b1) begin n_fail++; $display("FAIL fresh_load_done got %b want 1", ld_done); end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        addra    = 4'd3;
        tick();
        n_tests++;
        if (bank_sel !== 1'b1 || douta !== words[3]) begin
            n_fail++;
            $display("FAIL fresh_load_read got sel %b data %h want sel 1 data %h", bank_sel, douta, words[3]);
        end
    endtask

    task automatic test_random();
        int frame_len = 16;
        int sent      = 0;
        logic fired;
        for (int c = 0; c < 600; c++) begin
            rsta     = ($urandom_range(0, 149) == 0);
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = 8'($urandom);
            ld_last  = (sent == frame_len - 1);
            swap_req = ($urandom_range(0, 5) == 0);
            addra    = 4'($urandom_range(0, 15));
            fired    = ld_valid && !m_armed && !rsta;
            tick();
            n_tests++;
            if ({douta, bank_sel, ld_done, ld_ready, ld_err} !== {exp_dout, m_sel, m_armed, ~m_armed, exp_err}) begin
                n_fail++;
                $display("FAIL random[%0d] got %h/%b%b%b%b want %h/%b%b%b%b", c, douta, bank_sel, ld_done, ld_ready,
                         ld_err, exp_dout, m_sel, m_armed, ~m_armed, exp_err);
            end
            if (rsta) begin
                sent = 0;
            end else if (fired && ld_last) begin
                sent = 0;
                case ($urandom_range(0, 3))
                    0:       frame_len = 16;
                    1:       frame_len = 10;
                    2:       frame_len = 20;
                    default: frame_len = $urandom_range(2, 24);
                endcase
            end else if (fired) begin
                sent++;
            end
        end
        rsta     = 1'b0;
        ld_valid = 1'b0;
        swap_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_params();
        test_full_load();
        test_short_frame();
        test_long_frame();
        test_swap_ignored_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
